// File: rtl/rs_age_queue_pkg.sv
// Shared types for the age-ordered reservation station: dispatch/issue/CDB
// packets and the per-entry storage record.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package rs_age_queue_pkg;

  localparam int XLEN      = `XLEN;
  localparam int ROB_SIZE  = `ROB_SIZE;
  localparam int ROB_TAG_W = $clog2(ROB_SIZE);

  typedef logic [XLEN-1:0]      data_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  // Decoded instruction as delivered by dispatch.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      func;
    logic [4:0]      rd;
  } DP_RS_PACKET;

  // Instruction handed to execute with both operands resolved.
  typedef struct packed {
    DP_RS_PACKET packet;
    rob_tag_t    tag;
    data_t       rs1_value;
    data_t       rs2_value;
  } RS_EX_PACKET;

  // One common-data-bus broadcast.
  typedef struct packed {
    logic     valid;
    rob_tag_t tag;
    data_t    value;
  } CDB_PACKET;

  // Reservation-station entry payload; index 0 is rs1, index 1 is rs2.
  typedef struct packed {
    DP_RS_PACKET     packet;
    rob_tag_t        tag;
    logic [1:0]      src_wait;
    rob_tag_t [1:0]  src_tag;
    data_t [1:0]     src_value;
  } RS_AQ_ENTRY;

endpackage

// File: rtl/rs_age_queue_if.sv
// Dispatch, CDB snoop and issue signals of the age-ordered reservation station.
interface rs_age_queue_if
  import rs_age_queue_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int NUM_CDB  = 2,
  parameter int TAG_W    = ROB_TAG_W
);

  logic                             dp_valid;
  DP_RS_PACKET                      dp_packet;
  logic [TAG_W-1:0]                 dp_tag;
  logic [1:0][TAG_W-1:0]            src_tag;
  logic [1:0]                       src_wait;
  logic [1:0][XLEN-1:0]             src_value;
  logic                             dp_ready;
  logic [NUM_CDB-1:0]               cdb_valid;
  logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag;
  logic [NUM_CDB-1:0][XLEN-1:0]     cdb_value;
  logic                             flush;
  logic                             ex_ready;
  logic                             ex_valid;
  RS_EX_PACKET                      ex_packet;
  logic [$clog2(RS_DEPTH+1)-1:0]    free_count;

  // Producer side: dispatch, CDB and execute-stage control.
  modport master (
    output dp_valid, dp_packet, dp_tag, src_tag, src_wait, src_value,
    output cdb_valid, cdb_tag, cdb_value, flush, ex_ready,
    input  dp_ready, ex_valid, ex_packet, free_count
  );

  // Reservation-station side.
  modport slave (
    input  dp_valid, dp_packet, dp_tag, src_tag, src_wait, src_value,
    input  cdb_valid, cdb_tag, cdb_value, flush, ex_ready,
    output dp_ready, ex_valid, ex_packet, free_count
  );

endinterface

// File: rtl/rs_age_queue_age_select.sv
// Oldest-eligible picker: age[r][c]=1 means entry r was dispatched before
// entry c. Grants the eligible entry that no other eligible entry is older than.
module age_select #(
  parameter int N = 16
) (
  input  logic [N-1:0][N-1:0] age,
  input  logic [N-1:0]        elig,
  output logic [N-1:0]        grant
);

  // An eligible entry wins unless some other eligible entry is older.
  always_comb begin
    // NOTE: every output gets a default before any conditional write so no
    // path leaves it unassigned, which would otherwise infer a latch.
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = elig[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && elig[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_age_queue.sv
// Age-ordered reservation station: dispatch into the lowest free slot, snoop
// the CDBs for operand wakeup, and issue the oldest ready entry into a
// one-deep output register.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

module rs_age_queue
  import rs_age_queue_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int NUM_CDB  = 2,
  parameter int TAG_W    = $clog2(`ROB_SIZE)
) (
  input  logic           clock,
  input  logic           reset,
  rs_age_queue_if.slave  bus
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);

  logic [RS_DEPTH-1:0]               valid_q, valid_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
  RS_AQ_ENTRY                        ent_q [RS_DEPTH];
  RS_AQ_ENTRY                        ent_d [RS_DEPTH];
  RS_AQ_ENTRY                        new_ent;
  logic                              ex_valid_q;
  RS_EX_PACKET                       ex_packet_q, sel_pkt;
  logic [CNT_W-1:0]                  free_count;
  logic [RS_DEPTH-1:0]               elig, grant;
  logic [IDX_W-1:0]                  alloc_idx;
  logic                              dp_ready, dp_fire, load, any_grant;

  // Free slots derive from the registered valid bits only, so a slot freed by
  // this cycle's issue is not offered to this cycle's dispatch.
  always_comb begin
    free_count = CNT_W'(RS_DEPTH);
    for (int i = 0; i < RS_DEPTH; i++) free_count = free_count - CNT_W'(valid_q[i]);
  end

  assign dp_ready       = (free_count != '0);
  assign dp_fire        = bus.dp_valid && dp_ready && !bus.flush;
  assign load           = !ex_valid_q || bus.ex_ready;
  assign bus.dp_ready   = dp_ready;
  assign bus.free_count = free_count;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_packet  = ex_packet_q;

  // Lowest-index free slot; the descending scan leaves the smallest index last.
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Incoming entry, with same-cycle CDB capture; bus 0 is scanned last so the
  // lowest-numbered matching bus wins.
  always_comb begin
    new_ent.packet   = bus.dp_packet;
    new_ent.tag      = rob_tag_t'(bus.dp_tag);
    new_ent.src_wait = bus.src_wait;
    for (int op = 0; op < 2; op++) begin
      new_ent.src_tag[op]   = rob_tag_t'(bus.src_tag[op]);
      new_ent.src_value[op] = bus.src_value[op];
      if (bus.src_wait[op]) begin
        for (int b = NUM_CDB-1; b >= 0; b--) begin
          if (bus.cdb_valid[b] && bus.cdb_tag[b] == bus.src_tag[op]) begin
            new_ent.src_wait[op]  = 1'b0;
            new_ent.src_value[op] = bus.cdb_value[b];
          end
        end
      end
    end
  end

  // Eligibility uses registered wait bits, so a wakeup can issue no earlier
  // than the following edge.
  always_comb begin
    elig = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      elig[i] = valid_q[i] && !ent_q[i].src_wait[0] && !ent_q[i].src_wait[1];
    end
  end

  age_select #(.N(RS_DEPTH)) u_age_select (
    .age   (age_q),
    .elig  (elig),
    .grant (grant)
  );

  assign any_grant = |grant;

  // Mux the granted entry into issue-packet form.
  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) begin
        sel_pkt.packet    = ent_q[i].packet;
        sel_pkt.tag       = ent_q[i].tag;
        sel_pkt.rs1_value = ent_q[i].src_value[0];
        sel_pkt.rs2_value = ent_q[i].src_value[1];
      end
    end
  end

  // Next entry state: CDB wakeup, free on issue load, dispatch write, flush.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    ent_d   = ent_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int op = 0; op < 2; op++) begin
        if (ent_q[i].src_wait[op]) begin
          for (int b = NUM_CDB-1; b >= 0; b--) begin
            if (bus.cdb_valid[b] && rob_tag_t'(bus.cdb_tag[b]) == ent_q[i].src_tag[op]) begin
              ent_d[i].src_wait[op]  = 1'b0;
              ent_d[i].src_value[op] = bus.cdb_value[b];
            end
          end
        end
      end
    end
    if (load) valid_d = valid_d & ~grant;
    if (dp_fire) begin
      ent_d[alloc_idx]   = new_ent;
      valid_d[alloc_idx] = 1'b1;
      // Every currently resident entry becomes older than the newcomer.
      for (int j = 0; j < RS_DEPTH; j++) age_d[j][alloc_idx] = valid_q[j];
      age_d[alloc_idx] = '0;
    end
    if (bus.flush) valid_d = '0;
  end

  // Valid bits and age relations.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (reset) begin
      valid_q <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Entry payload storage.
  // NOTE: the payload array is deliberately not reset; it is only ever read
  // behind a valid bit, so clearing it would cost reset fan-out for nothing.
  always_ff @(posedge clock) begin
    ent_q <= ent_d;
  end

  // One-deep issue register: loads when empty or being consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_packet_q <= '0;
    end else if (bus.flush) begin
      ex_valid_q  <= 1'b0;
    end else if (load) begin
      ex_valid_q <= any_grant;
      if (any_grant) ex_packet_q <= sel_pkt;
    end
  end

endmodule

// File: tb/tb_rs_age_queue.sv
// Directed bench for rs_age_queue: latency, wakeup ordering, same-cycle CDB
// capture, full queue with back-pressure, flush and asynchronous reset.
module tb_rs_age_queue;
  import rs_age_queue_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   total;
  int   bad;

  rs_age_queue_if #(.RS_DEPTH(16), .NUM_CDB(2), .TAG_W(5)) bus ();

  rs_age_queue #(.RS_DEPTH(16), .NUM_CDB(2), .TAG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.dp_valid  = 1'b0;
    bus.src_wait  = 2'b00;
    bus.cdb_valid = 2'b00;
    bus.flush     = 1'b0;
  endtask

  task automatic drive_dp(input logic [4:0] tag, input logic [1:0] wt,
                          input logic [4:0] t1, input logic [4:0] t2,
                          input logic [31:0] v1, input logic [31:0] v2);
    bus.dp_valid     = 1'b1;
    bus.dp_tag       = tag;
    bus.dp_packet    = '{pc: {25'h0, tag, 2'b00}, func: 4'h3, rd: tag};
    bus.src_wait     = wt;
    bus.src_tag[0]   = t1;
    bus.src_tag[1]   = t2;
    bus.src_value[0] = v1;
    bus.src_value[1] = v2;
  endtask

  task automatic set_cdb(input int b, input logic [4:0] tag, input logic [31:0] value);
    bus.cdb_valid[b] = 1'b1;
    bus.cdb_tag[b]   = tag;
    bus.cdb_value[b] = value;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.ex_ready  = 1'b1;
    bus.dp_tag    = '0;
    bus.dp_packet = '0;
    bus.src_tag   = '0;
    bus.src_value = '0;
    bus.cdb_tag   = '0;
    bus.cdb_value = '0;
    idle();
    tick();
    tick();
    check("rst_ex_valid",  64'(bus.ex_valid), 64'h0);
    check("rst_free",      64'(bus.free_count), 64'd16);
    check("rst_dp_ready",  64'(bus.dp_ready), 64'h1);
    check("rst_ex_packet", 64'(bus.ex_packet.rs1_value), 64'h0);
    reset = 1'b0;

    // Ready instruction: accepted at one edge, issued at the next.
    drive_dp(5'd1, 2'b00, 5'd0, 5'd0, 32'h11, 32'h22);
    tick();
    idle();
    check("lat_free_after_dp", 64'(bus.free_count), 64'd15);
    check("lat_not_yet",       64'(bus.ex_valid), 64'h0);
    tick();
    check("lat_ex_valid", 64'(bus.ex_valid), 64'h1);
    check("lat_tag",      64'(bus.ex_packet.tag), 64'h1);
    check("lat_pc",       64'(bus.ex_packet.packet.pc), 64'h4);
    check("lat_rs1",      64'(bus.ex_packet.rs1_value), 64'h11);
    check("lat_rs2",      64'(bus.ex_packet.rs2_value), 64'h22);
    check("lat_free_back", 64'(bus.free_count), 64'd16);
    tick();
    check("lat_empty", 64'(bus.ex_valid), 64'h0);

    // Older A waits on tag 5; younger ready B issues first; then A wakes.
    drive_dp(5'd2, 2'b01, 5'd5, 5'd0, 32'h0, 32'h33);
    tick();
    drive_dp(5'd3, 2'b00, 5'd0, 5'd0, 32'h44, 32'h55);
    tick();
    idle();
    check("wk_a_blocked", 64'(bus.ex_valid), 64'h0);
    tick();
    check("wk_b_valid", 64'(bus.ex_valid), 64'h1);
    check("wk_b_tag",   64'(bus.ex_packet.tag), 64'h3);
    check("wk_b_rs2",   64'(bus.ex_packet.rs2_value), 64'h55);
    set_cdb(0, 5'd5, 32'h1234);
    set_cdb(1, 5'd5, 32'h9999);
    tick();
    idle();
    check("wk_no_same_cycle", 64'(bus.ex_valid), 64'h0);
    tick();
    check("wk_a_valid", 64'(bus.ex_valid), 64'h1);
    check("wk_a_tag",   64'(bus.ex_packet.tag), 64'h2);
    check("wk_a_rs1",   64'(bus.ex_packet.rs1_value), 64'h1234);
    check("wk_a_rs2",   64'(bus.ex_packet.rs2_value), 64'h33);
    check("wk_free",    64'(bus.free_count), 64'd16);
    tick();

    // Operand broadcast in the same cycle as its dispatch.
    drive_dp(5'd4, 2'b10, 5'd0, 5'd7, 32'h66, 32'h0);
    set_cdb(0, 5'd7, 32'hAA);
    tick();
    idle();
    check("byp_not_yet", 64'(bus.ex_valid), 64'h0);
    tick();
    check("byp_valid", 64'(bus.ex_valid), 64'h1);
    check("byp_tag",   64'(bus.ex_packet.tag), 64'h4);
    check("byp_rs1",   64'(bus.ex_packet.rs1_value), 64'h66);
    check("byp_rs2",   64'(bus.ex_packet.rs2_value), 64'hAA);
    tick();
    check("byp_empty", 64'(bus.ex_valid), 64'h0);

    // Fill: one instruction parks in the output register, sixteen fill the slots.
    bus.ex_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      drive_dp(5'(8 + k), 2'b00, 5'd0, 5'd0, 32'(k), 32'(256 + k));
      tick();
    end
    check("full_dp_ready", 64'(bus.dp_ready), 64'h0);
    check("full_free",     64'(bus.free_count), 64'd0);
    check("full_ex_valid", 64'(bus.ex_valid), 64'h1);
    check("full_ex_tag",   64'(bus.ex_packet.tag), 64'd8);
    drive_dp(5'd30, 2'b00, 5'd0, 5'd0, 32'hDEAD, 32'hBEEF);
    tick();
    idle();
    check("full_ignored", 64'(bus.free_count), 64'd0);
    check("full_hold",    64'(bus.ex_packet.tag), 64'd8);
    bus.ex_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("drain_tag",  64'(bus.ex_packet.tag), 64'(9 + k));
      check("drain_rs1",  64'(bus.ex_packet.rs1_value), 64'(1 + k));
      check("drain_free", 64'(bus.free_count), 64'(1 + k));
    end
    tick();
    check("drain_empty", 64'(bus.ex_valid), 64'h0);

    // Flush with five resident entries and a dispatch in the same cycle.
    bus.ex_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_dp(5'(1 + k), 2'b00, 5'd0, 5'd0, 32'(k), 32'(k));
      tick();
    end
    idle();
    check("fl_pre_free",  64'(bus.free_count), 64'd11);
    check("fl_pre_valid", 64'(bus.ex_valid), 64'h1);
    drive_dp(5'd7, 2'b00, 5'd0, 5'd0, 32'h7, 32'h7);
    bus.flush = 1'b1;
    tick();
    idle();
    check("fl_free",     64'(bus.free_count), 64'd16);
    check("fl_ex_valid", 64'(bus.ex_valid), 64'h0);
    bus.ex_ready = 1'b1;
    tick();
    check("fl_no_issue1", 64'(bus.ex_valid), 64'h0);
    tick();
    check("fl_no_issue2", 64'(bus.ex_valid), 64'h0);

    // Asynchronous reset while an issue is pending.
    bus.ex_ready = 1'b0;
    drive_dp(5'd10, 2'b00, 5'd0, 5'd0, 32'hA0, 32'hA1);
    tick();
    drive_dp(5'd11, 2'b00, 5'd0, 5'd0, 32'hB0, 32'hB1);
    tick();
    idle();
    check("ar_pre_valid", 64'(bus.ex_valid), 64'h1);
    check("ar_pre_tag",   64'(bus.ex_packet.tag), 64'd10);
    check("ar_pre_free",  64'(bus.free_count), 64'd15);
    #3;
    reset = 1'b1;
    #1;
    check("ar_ex_valid", 64'(bus.ex_valid), 64'h0);
    check("ar_free",     64'(bus.free_count), 64'd16);
    check("ar_dp_ready", 64'(bus.dp_ready), 64'h1);
    check("ar_ex_tag",   64'(bus.ex_packet.tag), 64'h0);
    tick();
    reset = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
    check("ar_no_stale1", 64'(bus.ex_valid), 64'h0);
    tick();
    check("ar_no_stale2", 64'(bus.ex_valid), 64'h0);
    check("ar_free_post", 64'(bus.free_count), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
